uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL provide parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL provide parameter BAUD, default 9600, meaning serial bit rate.
REQ-003 The block SHALL provide parameter FIFO_DEPTH, default 8, meaning byte capacity of the transmit FIFO; legal values are powers of two, 2 to 64.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL provide port din, input, 8 bits: byte to enqueue.
REQ-007 The block SHALL provide port wr_en, input, 1 bit: enqueue strobe, sampled each clk edge.
REQ-008 The block SHALL provide port tx, output, 1 bit: serial line (RsTx), idle high.
REQ-009 The block SHALL provide port full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-010 The block SHALL provide port empty, output, 1 bit: FIFO holds zero bytes.
REQ-011 The block SHALL provide port busy, output, 1 bit: serializer not in IDLE.
REQ-012 The block SHALL provide port overflow, output, 1 bit: one-cycle pulse on a dropped write.

Function
REQ-013 BAUD_DIV SHALL equal CLK_HZ/BAUD (integer division); every serial bit SHALL last exactly BAUD_DIV clk cycles.
REQ-014 A write with wr_en=1 and full=0 SHALL store din at the FIFO tail on that edge.
REQ-015 A write with wr_en=1 and full=1 (value at start of cycle) SHALL be dropped and overflow SHALL be 1 for the following cycle only, even if the serializer pops in the same cycle.
REQ-016 full, empty and the occupancy count SHALL be registered and updated on the edge of any push or pop; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-017 Serializer states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-018 IDLE -> START when empty=0: pop head byte into shift register; tx=0 from the next edge; write into an empty FIFO at edge N SHALL yield tx=0 from edge N+2.
REQ-019 START -> DATA after BAUD_DIV cycles; DATA SHALL send 8 bits LSB first, BAUD_DIV cycles each, using a 3-bit bit index.
REQ-020 DATA -> STOP (or PARITY) after bit 7; STOP drives tx=1 for BAUD_DIV cycles.
REQ-021 At the end of STOP: if empty=0, the next byte SHALL be popped and START SHALL begin on the very next cycle (no idle gap); otherwise return to IDLE.
REQ-022 The baud counter SHALL reset to 0 on every state entry and wrap at BAUD_DIV-1.
REQ-023 busy SHALL be 1 in every state except IDLE; tx SHALL be 1 in IDLE.
REQ-024 Writes SHALL be accepted in all serializer states; a byte in flight SHALL never be altered by later writes.

Reset
REQ-025 When reset=1 at an edge: state=IDLE, FIFO flushed, tx=1, full=0, empty=1, busy=0, overflow=0 from that edge, including mid-frame (truncated frame is not completed).
REQ-026 wr_en asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state SHALL follow DATA, sending one even-parity bit (XOR of 8 data bits) for BAUD_DIV cycles; frame = 11 bits.
REQ-028 Macro UART_TX_PARITY_EN undefined: PARITY state and logic SHALL be absent; DATA -> STOP directly; frame = 10 bits.

Verification
REQ-029 CLK_HZ=16, BAUD=1 (BAUD_DIV=16); write 0x41 after reset -> tx=0 from edge N+2 for 16 cycles, then 1,0,0,0,0,0,1,0 at 16 cycles each, stop high 16 cycles, busy falls, empty=1.
REQ-030 Write 0x0D, 0x0A on consecutive cycles -> two frames back-to-back, second start bit on the cycle after first stop bit ends, no idle gap.
REQ-031 Write FIFO_DEPTH+2 bytes consecutively (0x00..0x09, depth 8) -> full=1, overflow pulses on last writes not absorbed by the first pop, transmitted sequence matches accepted bytes in order.
REQ-032 Assert reset during DATA bit 3 of 0x55 with 3 bytes queued -> tx=1, empty=1, busy=0 next cycle; no further frames.
REQ-033 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; stop bit follows parity.
REQ-034 Simultaneous wr_en and pop with FIFO at depth 4 -> occupancy stays 4, full/empty unchanged.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of an 8-N-1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8-E-1).
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_byte;
  logic             baud_done;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             push;
  logic             pop;

  assign baud_done = (baud_cnt == CNT_LAST);
  assign push      = wr_en && !full;
  // The serializer pulls the head byte when idle, or at the last cycle of STOP
  // so the next START follows with no idle gap.
  assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_done));

  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      full     <= (count_next == DEPTH_CNT);
      empty    <= (count_next == '0);
      overflow <= wr_en && full;
    end
  end

  // NOTE: storage is deliberately not reset; flushing the pointers is enough and
  // keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // tx is registered from the current state, so it trails the state by one cycle
  // uniformly and every bit still lasts exactly BAUD_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_byte <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (!empty) begin
            shift_byte <= mem[rd_ptr];
            state      <= START;
            busy       <= 1'b1;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_done) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          tx <= shift_byte[bit_idx];
          if (baud_done) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= ^shift_byte;
          if (baud_done) state <= STOP;
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            if (!empty) begin
              shift_byte <= mem[rd_ptr];
              state      <= START;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random writes checked each cycle against
// a timeline model (byte queue plus frame start times).
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int DEPTH  = 8;
  localparam int D      = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  localparam longint FD = longint'(NBITS * D);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, full, empty, busy, overflow;

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en),
    .tx(tx), .full(full), .empty(empty), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: queued bytes, the edge at which the current frame was popped, and its byte.
  logic [7:0] q[$];
  logic       ovf_exp = 1'b0;
  longint     t = 0;
  longint     p_last = -1000000;
  logic [7:0] frame_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, got, exp);
  endtask

  // Line level of bit k of a frame: start, 8 data LSB first, [parity], stop.
  function automatic logic frame_bit(input int k, input logic [7:0] b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    int  sz;
    logic exp_tx;
    @(posedge clk);
    t++;
    if (reset) begin
      q.delete();
      ovf_exp = 1'b0;
      p_last  = -1000000;
    end else begin
      sz = q.size();
      ovf_exp = wr_en && (sz == DEPTH);
      if (sz > 0 && t >= p_last + FD) begin
        frame_byte = q.pop_front();
        p_last     = t;
      end
      if (wr_en && sz < DEPTH) q.push_back(din);
    end
    #1;
    exp_tx = (t > p_last && t <= p_last + FD) ? frame_bit(int'((t - p_last - 1) / D), frame_byte) : 1'b1;
    check("tx", 32'(tx), 32'(exp_tx));
    check("busy", 32'(busy), 32'(t >= p_last && t < p_last + FD));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(ovf_exp));
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() > 0 || t < p_last + FD) && guard < 20000) begin
      tick();
      guard++;
    end
    check("drain_timeout", 32'(guard < 20000), 32'd1);
    idle(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset, with a write strobe during reset that must be ignored.
    tick();
    wr_en = 1'b1;
    din   = 8'hFF;
    tick();
    wr_en = 1'b0;
    reset = 1'b0;
    idle(3);

    // Single frame.
    wr(8'h41);
    drain();

    // Back-to-back frames.
    wr(8'h0D);
    wr(8'h0A);
    drain();

    // Burst past capacity.
    for (int i = 0; i < DEPTH + 2; i++) wr(8'(i));
    drain();

    // Reset in the middle of data bit 3 of 0x55 with 3 more bytes queued.
    wr(8'h55);
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    while (t < p_last + 1 + 4 * D + 2) tick();
    do_reset();
    idle(2 * int'(FD));

    // Push coinciding with a pop while four bytes are queued.
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    while (t + 1 < p_last + FD) tick();
    wr(8'hA5);
    drain();

    // Parity-sensitive bytes.
    wr(8'h07);
    wr(8'h03);
    drain();

    // Random traffic, with one random reset.
    for (int i = 0; i < 1200; i++) begin
      wr_en = ($urandom_range(0, 5) == 0);
      din   = 8'($urandom);
      reset = (i == 700);
      tick();
    end
    wr_en = 1'b0;
    reset = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
